// File: rtl/if_fetch_pkg.sv
// Shared if_fetch definitions: PCCTRL encoding macros, NOP encoding and fetch FSM states.
// Optional feature macro honoured by this slice: IF_MISALIGN_TRAP_EN.
`ifndef IF_FETCH_DEFS_SVH
`define IF_FETCH_DEFS_SVH
`define WIDTH_PCCTRL 4
`define PCCTRL_J 3
`define PCCTRL_B 2
`define PCCTRL_B_EQ 2'b00
`define PCCTRL_B_NE 2'b01
`define PCCTRL_B_LT 2'b10
`define PCCTRL_B_GEQ 2'b11
`endif

package if_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    TRAP  = 2'd3
  } fetch_state_e;

  // Resolve the 2-bit branch condition against the EX comparator flags.
  function automatic logic branch_cond(input logic [1:0] code, input logic zero, input logic lt);
    logic cond;
    cond = 1'b0;
    case (code)
      `PCCTRL_B_EQ:  cond = zero;
      `PCCTRL_B_NE:  cond = ~zero;
      `PCCTRL_B_LT:  cond = lt;
      `PCCTRL_B_GEQ: cond = ~lt;
      default:       cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Instruction buffer for if_fetch: synchronous FIFO with flush and a registered head entry.
module if_fetch_fifo #(
  parameter int              WIDTH      = 64,
  parameter int              DEPTH      = 4,
  parameter int              CW         = $clog2(DEPTH) + 1,
  parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic [WIDTH-1:0] head_next;

  assign rd_next = rd_ptr + 1'b1;

  // The head is kept in its own register so decode sees a flop, not a read mux.
  always_comb begin
    head_next = head_data;
    if (count == '0 && push)
      head_next = push_data;
    else if (pop && count == CW'(1) && push)
      head_next = push_data;
    else if (pop && count > CW'(1))
      head_next = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_data <= RESET_HEAD;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      count     <= count + CW'(push) - CW'(pop);
      head_data <= head_next;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and buffers results for decode.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned redirect traps instead of being forced aligned).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int             XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int             FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  input  logic [`WIDTH_PCCTRL-1:0] ex_pcctrl,
  input  logic                     ex_zero,
  input  logic                     ex_lt,
  input  logic [XLEN-1:0]          ex_target,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [XLEN-1:0]          if_pc,
  output logic [31:0]              if_inst
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic                     if_misalign
`endif
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e     state, state_next;
  logic [XLEN-1:0]  fetch_pc, resp_pc, redirect_pc;
  logic [CW-1:0]    outstanding, outstanding_next, discard, discard_next, fifo_count;
  logic [CW:0]      occupancy;
  logic             taken, pop, fifo_pop, fifo_push, drop, grant;
  logic [XLEN-1:0]  head_pc;
  logic [31:0]      head_inst;

  assign taken = ex_valid & (ex_pcctrl[`PCCTRL_J] |
                 (ex_pcctrl[`PCCTRL_B] & branch_cond(ex_pcctrl[1:0], ex_zero, ex_lt)));

`ifdef IF_MISALIGN_TRAP_EN
  logic            trap_pending;
  logic [XLEN-1:0] trap_pc;
  logic            unused_target_lsb;
  assign unused_target_lsb = ex_target[0];
  assign redirect_pc = {ex_target[XLEN-1:1], 1'b0};
`else
  logic [1:0] unused_target_lsbs;
  assign unused_target_lsbs = ex_target[1:0];
  assign redirect_pc = {ex_target[XLEN-1:2], 2'b00};
`endif

  // Everything granted but not yet drained by decode counts against the buffer.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign imem_req  = (state != BOOT) & (state != TRAP) & ~taken & (occupancy < DEPTH_C);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;

`ifdef IF_MISALIGN_TRAP_EN
  assign if_valid    = ((state == TRAP) ? trap_pending : (fifo_count != '0)) & ~taken;
  assign if_pc       = (state == TRAP) ? trap_pc : head_pc;
  assign if_inst     = (state == TRAP) ? NOP_INST : head_inst;
  assign if_misalign = (state == TRAP) & if_valid;
`else
  assign if_valid = (fifo_count != '0) & ~taken;
  assign if_pc    = head_pc;
  assign if_inst  = head_inst;
`endif

  assign pop       = if_valid & if_ready;
  assign fifo_pop  = pop & (state != TRAP);
  assign drop      = imem_rvalid & (taken | (discard != '0));
  assign fifo_push = imem_rvalid & ~drop;

  // A redirect turns every response still in flight into one to discard.
  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);
  assign discard_next = taken ? (outstanding - CW'(imem_rvalid))
                              : (discard - CW'(imem_rvalid & (discard != '0)));

  always_comb begin
    state_next = state;
    case (state)
      BOOT:       state_next = RUN;
      RUN, DRAIN: state_next = (discard_next != '0) ? DRAIN : RUN;
      TRAP:       state_next = TRAP;
      default:    state_next = BOOT;
    endcase
    if (taken) begin
      state_next = (discard_next != '0) ? DRAIN : RUN;
`ifdef IF_MISALIGN_TRAP_EN
      if (ex_target[1]) state_next = TRAP;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (taken) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (grant)     fetch_pc <= fetch_pc + XLEN'(4);
        if (fifo_push) resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pending <= 1'b0;
      trap_pc      <= RESET_PC;
    end else if (taken) begin
      trap_pending <= ex_target[1];
      trap_pc      <= redirect_pc;
    end else if (pop && state == TRAP) begin
      trap_pending <= 1'b0;
    end
  end
`endif

  if_fetch_fifo #(
    .WIDTH     (XLEN + 32),
    .DEPTH     (FIFO_DEPTH),
    .CW        (CW),
    .RESET_HEAD({RESET_PC, 32'h0})
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data({resp_pc, imem_rdata}),
    .pop      (fifo_pop),
    .flush    (taken),
    .head_data({head_pc, head_inst}),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Randomized self-checking bench for if_fetch against a queue-based reference model.
module tb_if_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]  PC_J     = 4'(1 << `PCCTRL_J);
  localparam logic [3:0]  PC_B     = 4'(1 << `PCCTRL_B);
  localparam logic [3:0]  PC_BEQ   = PC_B | 4'(`PCCTRL_B_EQ);
  localparam logic [3:0]  PC_BNE   = PC_B | 4'(`PCCTRL_B_NE);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_zero = 1'b0, ex_lt = 1'b0;
  logic [3:0]  ex_pcctrl = '0;
  logic [31:0] ex_target = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_pc, if_inst;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  always #5 clk = ~clk;

  if_fetch #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pcctrl(ex_pcctrl), .ex_zero(ex_zero), .ex_lt(ex_lt),
    .ex_target(ex_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
`ifdef IF_MISALIGN_TRAP_EN
    , .if_misalign(if_misalign)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
  typedef struct { int due; logic [31:0] addr; } mem_rsp_t;

  entry_t      out_q[$];
  bit          inflight_stale[$];
  mem_rsp_t    mem_q[$];
  int          last_due;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] m_fetch_pc, m_resp_pc, m_trap_pc;
  bit          m_boot, m_trap, m_trap_pending;
  bit          seen_valid;
  logic [31:0] seen_pc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit model_taken(input bit v, input logic [3:0] c, input bit z, input bit lt);
    bit cond;
    case (c[1:0])
      `PCCTRL_B_EQ: cond = z;
      `PCCTRL_B_NE: cond = !z;
      `PCCTRL_B_LT: cond = lt;
      default:      cond = !lt;
    endcase
    return v && (c[`PCCTRL_J] || (c[`PCCTRL_B] && cond));
  endfunction

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    ex_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
    mem_q.delete(); out_q.delete(); inflight_stale.delete();
    last_due = -1;
    m_fetch_pc = RESET_PC; m_resp_pc = RESET_PC;
    m_boot = 1; m_trap = 0; m_trap_pending = 0; m_trap_pc = RESET_PC;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_if_pc", if_pc, RESET_PC);
    checkOutput("rst_if_inst", if_inst, 0);
`ifdef IF_MISALIGN_TRAP_EN
    checkOutput("rst_if_misalign", if_misalign, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, compare just after, advance the model, then the edge.
  task automatic applyStimulus(input bit ev, input logic [3:0] pcc, input bit z, input bit lt,
                               input logic [31:0] tgt, input bit gnt, input bit rdy);
    bit rv, tk, exp_valid, pop, exp_req, hs, s;
    int lat, due;
    logic [31:0] hs_addr, tpc;
    @(negedge clk);
    ex_valid = ev; ex_pcctrl = pcc; ex_zero = z; ex_lt = lt; ex_target = tgt;
    imem_gnt = gnt; if_ready = rdy;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cycle);
    imem_rvalid = rv;
    imem_rdata = rv ? inst_of(mem_q[0].addr) : $urandom;
    #1;
    tk = model_taken(ev, pcc, z, lt);
    exp_valid = m_trap ? (m_trap_pending && !tk) : (out_q.size() != 0 && !tk);
    pop = exp_valid && rdy;
    exp_req = !m_boot && !m_trap && !tk &&
              (inflight_stale.size() + out_q.size() - int'(pop) < DEPTH);
    checkOutput("imem_req", imem_req, exp_req);
    if (exp_req) checkOutput("imem_addr", imem_addr, m_fetch_pc);
    checkOutput("if_valid", if_valid, exp_valid);
    if (exp_valid) begin
      checkOutput("if_pc", if_pc, m_trap ? m_trap_pc : out_q[0].pc);
      checkOutput("if_inst", if_inst, m_trap ? NOP : out_q[0].inst);
    end
`ifdef IF_MISALIGN_TRAP_EN
    checkOutput("if_misalign", if_misalign, m_trap && exp_valid);
`endif
    checkOutput("occupancy_bound",
                32'(int'(dut.outstanding) + int'(dut.fifo_count) <= DEPTH), 1);
    seen_valid = if_valid; seen_pc = if_pc;
    hs = imem_req && gnt; hs_addr = imem_addr;

    if (rv) void'(mem_q.pop_front());
    if (hs) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cycle + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{due, hs_addr});
    end
    if (tk) begin
`ifdef IF_MISALIGN_TRAP_EN
      tpc = {tgt[31:1], 1'b0};
      m_trap = tgt[1]; m_trap_pending = tgt[1]; m_trap_pc = tpc;
`else
      tpc = {tgt[31:2], 2'b00};
`endif
      m_fetch_pc = tpc; m_resp_pc = tpc;
      if (rv && inflight_stale.size() > 0) void'(inflight_stale.pop_front());
      foreach (inflight_stale[i]) inflight_stale[i] = 1;
      out_q.delete();
    end else begin
      if (pop) begin
        if (m_trap) m_trap_pending = 0;
        else void'(out_q.pop_front());
      end
      if (rv && inflight_stale.size() > 0) begin
        s = inflight_stale.pop_front();
        if (!s) begin
          out_q.push_back('{m_resp_pc, inst_of(m_resp_pc)});
          m_resp_pc += 32'd4;
        end
      end
      if (exp_req && gnt) begin
        inflight_stale.push_back(0);
        m_fetch_pc += 32'd4;
      end
    end
    m_boot = 0;
    @(posedge clk);
    cycle++;
  endtask

  task automatic runIdle(input int n, input bit gnt, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 4'h0, 0, 0, 32'h0, gnt, rdy);
  endtask

  task automatic expectFirstPc(input string tag, input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(0, 4'h0, 0, 0, 32'h0, 1, 1);
      found = seen_valid;
    end
    if (found) checkOutput(tag, seen_pc, pc);
    else checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] tgt;
    doReset();
    // Streaming at one instruction per cycle from reset.
    runIdle(12, 1, 1);
    // Backpressure from decode, then release.
    runIdle(10, 1, 0);
    runIdle(10, 1, 1);
    // Taken beq with several requests in flight.
    lat_min = 3; lat_max = 3;
    runIdle(6, 1, 1);
    applyStimulus(1, PC_BEQ, 1, 0, 32'h100, 1, 1);
    expectFirstPc("beq_first_pc", 32'h100);
    // bne with equal operands falls through.
    applyStimulus(1, PC_BNE, 1, 0, 32'h800, 1, 1);
    runIdle(6, 1, 1);
    // Back-to-back redirects: latest target wins.
    applyStimulus(1, PC_J, 0, 0, 32'h200, 1, 1);
    applyStimulus(1, PC_J, 0, 0, 32'h300, 1, 1);
    expectFirstPc("b2b_first_pc", 32'h300);
    // PC wrap through zero.
    lat_min = 1; lat_max = 1;
    applyStimulus(1, PC_J, 0, 0, 32'hFFFF_FFF4, 1, 1);
    runIdle(10, 1, 1);
`ifdef IF_MISALIGN_TRAP_EN
    lat_min = 2; lat_max = 2;
    runIdle(4, 1, 1);
    applyStimulus(1, PC_J, 0, 0, 32'h0000_0106, 1, 1);
    runIdle(3, 1, 0);
    runIdle(4, 1, 1);
    applyStimulus(1, PC_J, 0, 0, 32'h40, 1, 1);
    expectFirstPc("trap_exit_pc", 32'h40);
`endif
    // Randomized traffic with a mid-run reset.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) doReset();
      case ($urandom_range(0, 3))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2:       tgt = $urandom & 32'hFFE;
        default: tgt = ($urandom & 32'h3FC) | 32'h1000;
      endcase
      applyStimulus($urandom_range(0, 11) == 0, 4'($urandom), 1'($urandom), 1'($urandom),
                    tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
